prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/word_assembler.sv | 43 ++++
 rtl/prog_loader.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the program loader: state encoding, default sizes and
// the little-endian byte shift used by the word assembler.
package cpu_pkg;

    localparam int unsigned ADDR_W_DEF  = 8;
    localparam int unsigned TIMEOUT_DEF = 1023;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StDone = 2'd2,
        StErr  = 2'd3
    } ld_state_e;

    // New byte enters at the top so the first byte ends up in bits 7:0.
    function automatic logic [31:0] le_shift(input logic [31:0] w, input logic [7:0] b);
        return {b, w[31:8]};
    endfunction

endpackage

// File: rtl/word_assembler.sv
// Collects four bytes into a 32-bit word, little-endian; flags the cycle in
// which the fourth byte is accepted and presents the completed word then.
module word_assembler
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        xfer,
    input  logic [7:0]  in_byte,
    output logic [31:0] word,
    output logic        word_done
);

    logic [31:0] sh_q, sh_d;
    logic [1:0]  idx_q, idx_d;

    always_comb begin
        sh_d  = sh_q;
        idx_d = idx_q;
        if (clr) begin
            sh_d  = '0;
            idx_d = '0;
        end else if (xfer) begin
            sh_d  = le_shift(sh_q, in_byte);
            idx_d = idx_q + 2'd1;
        end
    end

    assign word      = le_shift(sh_q, in_byte);
    assign word_done = xfer && !clr && (idx_q == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q  <= '0;
            idx_q <= '0;
        end else begin
            sh_q  <= sh_d;
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a program from a host byte stream into CPU instruction memory and
// enables the CPU once the requested number of words has been written.
module prog_loader
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [7:0]        in_byte,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we_IM,
    output logic [31:0]       codein,
    output logic [ADDR_W-1:0] im_addr,
    output logic              en,
    output logic              busy,
    output logic              err
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [31:0]       codein_q, codein_d;
    logic [ADDR_W-1:0] im_addr_q, im_addr_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              err_q, err_d;

    logic        xfer;
    logic        asm_clr;
    logic [31:0] asm_word;
    logic        asm_done;

    // in_ready_q is high exactly while in LOAD, so it gates the handshake.
    assign xfer    = in_valid && in_ready_q;
    assign asm_clr = (state_q != StLoad);

    word_assembler u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (asm_clr),
        .xfer      (xfer),
        .in_byte   (in_byte),
        .word      (asm_word),
        .word_done (asm_done)
    );

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        waddr_d   = waddr_q;
        tmo_d     = tmo_q;
        we_d      = 1'b0;
        codein_d  = codein_q;
        im_addr_d = im_addr_q;

        unique case (state_q)
            StLoad: begin
                if (asm_done) begin
                    we_d      = 1'b1;
                    codein_d  = asm_word;
                    im_addr_d = waddr_q;
                    waddr_d   = waddr_q + 1'b1;
                    tmo_d     = '0;
                    if (waddr_q == len_q - 1'b1) begin
                        state_d = StDone;
                    end
                end else if (xfer) begin
                    tmo_d = '0;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StErr;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StIdle, StDone, StErr: begin
                if (start) begin
                    len_d   = len;
                    waddr_d = '0;
                    tmo_d   = '0;
                    state_d = (len != '0) ? StLoad : StDone;
                end
            end
            default: state_d = StIdle;
        endcase

        in_ready_d = (state_d == StLoad);
        busy_d     = (state_d == StLoad);
        err_d      = (state_d == StErr);
        // Held in DONE; an accepted start drops it for at least one cycle.
        en_d       = (state_q == StDone) && (state_d == StDone) && !start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            len_q      <= '0;
            waddr_q    <= '0;
            tmo_q      <= '0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            codein_q   <= '0;
            im_addr_q  <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            waddr_q    <= waddr_d;
            tmo_q      <= tmo_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            codein_q   <= codein_d;
            im_addr_q  <= im_addr_d;
            en_q       <= en_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign in_ready = in_ready_q;
    assign we_IM    = we_q;
    assign codein   = codein_q;
    assign im_addr  = im_addr_q;
    assign en       = en_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
